// File: rtl/expye_dmem_pkg.sv
// Shared definitions for the expye data-memory responder: FSM encodings,
// bus width, byte-lane constants and reset/write-enable levels.
package expye_dmem_pkg;

    localparam int unsigned DMEM_DATA_W = 32;
    localparam int unsigned DMEM_LANES  = DMEM_DATA_W / 8;
    localparam int unsigned DMEM_CNT_W  = 4;

    localparam logic [DMEM_LANES-1:0] SelNone   = 4'b0000;
    localparam logic [DMEM_LANES-1:0] SelWord   = 4'b1111;
    localparam logic [DMEM_LANES-1:0] SelHalfLo = 4'b0011;
    localparam logic [DMEM_LANES-1:0] SelHalfHi = 4'b1100;

    localparam logic RstEnable    = 1'b1;
    localparam logic RstDisable   = 1'b0;
    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } dmem_state_e;

endpackage

// File: rtl/expye_dmem_array.sv
// Single-port synchronous RAM with per-byte-lane write enables and a
// registered read port (read-before-write on a shared access).
module expye_dmem_array
    import expye_dmem_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                   clk,
    input  logic                   en,
    input  logic [DMEM_LANES-1:0]  we,
    input  logic [DEPTH_LOG2-1:0]  addr,
    input  logic [DMEM_DATA_W-1:0] wdata,
    output logic [DMEM_DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [DMEM_DATA_W-1:0] mem [0:DEPTH-1];

    // Byte-lane writes and registered read on an enabled access
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < int'(DMEM_LANES); i++) begin
                if (we[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/expye_dmem_responder.sv
// Data-memory responder for the expye_cpu MEM stage: one outstanding
// request, WAIT_CYCLES of modelled latency, byte-lane stores, word loads.
// Optional build macro: DMEM_ALIGN_CHECK_EN (flag and suppress misaligned
// word/half accesses; when undefined resp_err is tied low).
module expye_dmem_responder
    import expye_dmem_pkg::*;
#(
    parameter int unsigned DATA_W      = DMEM_DATA_W,
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [3:0]        req_sel,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              stall_req
);

    dmem_state_e              state_q, state_d;
    logic [DMEM_CNT_W-1:0]    cnt_q, cnt_d;
    logic                     access_c;
    logic                     accept_c;

    logic                     hold_we;
    logic [31:0]              hold_addr;
    logic [3:0]               hold_sel;
    logic [DATA_W-1:0]        hold_wdata;

    logic                     cur_we;
    logic [31:0]              cur_addr;
    logic [3:0]               cur_sel;
    logic [DATA_W-1:0]        cur_wdata;
    logic                     misalign_c;

    logic                     ram_en;
    logic [DMEM_LANES-1:0]    ram_we;
    logic [DATA_W-1:0]        ram_rdata;
    logic                     unused_addr;

    assign accept_c  = req_valid & (state_q == S_IDLE);
    assign stall_req = (state_q != S_IDLE) | accept_c;

    // In IDLE the live request drives the array (zero-wait path); otherwise the held copy
    assign cur_we    = (state_q == S_IDLE) ? req_we    : hold_we;
    assign cur_addr  = (state_q == S_IDLE) ? req_addr  : hold_addr;
    assign cur_sel   = (state_q == S_IDLE) ? req_sel   : hold_sel;
    assign cur_wdata = (state_q == S_IDLE) ? req_wdata : hold_wdata;

`ifdef DMEM_ALIGN_CHECK_EN
    assign misalign_c = ((cur_sel == SelWord) & (cur_addr[1:0] != 2'b00))
                      | (((cur_sel == SelHalfLo) | (cur_sel == SelHalfHi)) & cur_addr[0]);
`else
    assign misalign_c = 1'b0;
`endif

    // Bits above the array index and the byte offset do not select a word
    assign unused_addr = ^{cur_addr[31:DEPTH_LOG2+2], cur_addr[1:0]};

    // Array access happens on the edge entering RESP; a reset on that edge cancels it
    assign ram_en = access_c & (rst == RstDisable);
    assign ram_we = (ram_en & (cur_we == WriteEnable) & ~misalign_c) ? cur_sel : SelNone;

    expye_dmem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (cur_addr[DEPTH_LOG2+1:2]),
        .wdata (cur_wdata),
        .rdata (ram_rdata)
    );

    // Next-state and wait-counter logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        access_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d  = S_RESP;
                        access_c = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = DMEM_CNT_W'(WAIT_CYCLES);
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q <= DMEM_CNT_W'(1)) begin
                    state_d  = S_RESP;
                    cnt_d    = '0;
                    access_c = 1'b1;
                end else begin
                    cnt_d = cnt_q - DMEM_CNT_W'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, holding registers and registered response outputs
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            hold_we    <= 1'b0;
            hold_addr  <= '0;
            hold_sel   <= '0;
            hold_wdata <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_ready  <= (state_d == S_IDLE);
            resp_valid <= (state_q == S_RESP);
            resp_err   <= (state_q == S_RESP) & misalign_c;
            if ((state_q == S_RESP) & ~hold_we & ~misalign_c) begin
                resp_rdata <= ram_rdata;
            end else begin
                resp_rdata <= '0;
            end
            if (accept_c) begin
                hold_we    <= req_we;
                hold_addr  <= req_addr;
                hold_sel   <= req_sel;
                hold_wdata <= req_wdata;
            end
        end
    end

endmodule

// File: tb/tb_expye_dmem_responder.sv
// Directed bench for expye_dmem_responder (WAIT_CYCLES=2, DEPTH_LOG2=10).
// Honours DMEM_ALIGN_CHECK_EN to choose the misaligned-store expectation.
module tb_expye_dmem_responder;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [3:0]  req_sel;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        stall_req;

    int n_checks = 0;
    int n_errors = 0;

    expye_dmem_responder #(
        .DATA_W      (32),
        .DEPTH_LOG2  (10),
        .WAIT_CYCLES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_sel    (req_sel),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .stall_req  (stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One full transaction; entered and left at posedge+1 with the DUT idle
    task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                        input logic [3:0] sel, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err);
        int   lat;
        logic stall_gap;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_sel   = sel;
        req_wdata = wdata;
        #1;
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
        check({tag, "_stall_req"}, 32'(stall_req), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_wdata = 32'hFFFF_FFFF;
        req_addr  = 32'hFFFF_FFFC;
        lat       = 0;
        stall_gap = 1'b0;
        while (!resp_valid && lat < 20) begin
            if (!stall_req) stall_gap = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd3);
        check({tag, "_stall_hold"}, 32'(stall_gap), 32'd0);
        check({tag, "_stall_resp"}, 32'(stall_req), 32'd0);
        check({tag, "_ready_resp"}, 32'(req_ready), 32'd1);
        check({tag, "_rdata"}, resp_rdata, exp_rdata);
        check({tag, "_err"}, 32'(resp_err), 32'(exp_err));
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, 32'(resp_valid), 32'd0);
    endtask

    initial begin
        int seen;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_sel   = '0;
        req_wdata = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_stall", 32'(stall_req), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Full-word store then load
        xact("st_word", 1'b1, 32'h10, 4'b1111, 32'hDEAD_BEEF, 32'h0, 1'b0);
        xact("ld_word", 1'b0, 32'h10, 4'b1111, 32'h0, 32'hDEAD_BEEF, 1'b0);

        // Single byte lane 1 store
        xact("st_byte", 1'b1, 32'h10, 4'b0010, 32'h0000_AA00, 32'h0, 1'b0);
        xact("ld_byte", 1'b0, 32'h10, 4'b1111, 32'h0, 32'hDEAD_AAEF, 1'b0);

        // sel=0000 store responds but changes nothing
        xact("st_nosel", 1'b1, 32'h10, 4'b0000, 32'h1111_1111, 32'h0, 1'b0);
        xact("ld_nosel", 1'b0, 32'h10, 4'b0000, 32'h0, 32'hDEAD_AAEF, 1'b0);

        // Address wrap modulo 4 KiB
        xact("st_wrap", 1'b1, 32'h1000, 4'b1111, 32'h1234_5678, 32'h0, 1'b0);
        xact("ld_wrap", 1'b0, 32'h0, 4'b1111, 32'h0, 32'h1234_5678, 1'b0);

        // Reset while waiting abandons the store
        xact("st_prior", 1'b1, 32'h20, 4'b1111, 32'hCAFE_F00D, 32'h0, 1'b0);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h20;
        req_sel   = 4'b1111;
        req_wdata = 32'h0000_0055;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst       = 1'b1;
        seen      = 0;
        @(posedge clk);
        #1;
        if (resp_valid) seen++;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (resp_valid) seen++;
        end
        check("rst_mid_no_resp", 32'(seen), 32'd0);
        check("rst_mid_ready", 32'(req_ready), 32'd1);
        xact("ld_after_rst", 1'b0, 32'h20, 4'b1111, 32'h0, 32'hCAFE_F00D, 1'b0);

        // Misaligned full-word store at 0x22 (word 8)
`ifdef DMEM_ALIGN_CHECK_EN
        xact("st_misalign", 1'b1, 32'h22, 4'b1111, 32'hA5A5_A5A5, 32'h0, 1'b1);
        xact("ld_misalign", 1'b0, 32'h20, 4'b1111, 32'h0, 32'hCAFE_F00D, 1'b0);
`else
        xact("st_misalign", 1'b1, 32'h22, 4'b1111, 32'hA5A5_A5A5, 32'h0, 1'b0);
        xact("ld_misalign", 1'b0, 32'h20, 4'b1111, 32'h0, 32'hA5A5_A5A5, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
